l2_req_arbiter: RTL and testbench

- Shares the single next-level (L2) request port between the instruction cache and the data cache.
- Buffers line-fill/write requests from each L1 in a private FIFO and grants them round-robin into one registered output slot with a valid/ready handshake toward L2.
- Keeps per-source grant counters and an L2 back-pressure stall counter for the statistics module.

---
 rtl/l2_req_arbiter.sv | 162 ++++++++++++++++
 tb/tb_l2_req_arbiter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/l2_req_arbiter.sv
// Shares the single L2 request port between the I-cache and the D-cache.
// Each source is queued in a private FIFO; grants alternate round-robin into one registered slot.
module l2_req_fifo #(
  parameter int W     = 26,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic [W-1:0]               head,
  output logic                       not_full,
  output logic                       not_empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = PTR_W + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0]    count;

  assign not_full  = (count != FULL);
  assign not_empty = (count != '0);
  assign head      = mem[rd_ptr];

  // NOTE: storage needs no reset; the pointers and count alone decide what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // NOTE: sequential state uses <= so every flop samples pre-edge values, whatever the statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

module l2_req_arbiter #(
  parameter int ADDR_W = 26,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req_valid,
  input  logic [ADDR_W-1:0] i_req_addr,
  output logic              i_req_ready,
  input  logic              d_req_valid,
  input  logic [ADDR_W-1:0] d_req_addr,
  input  logic              d_req_write,
  output logic              d_req_ready,
  output logic              l2_valid,
  output logic [ADDR_W-1:0] l2_addr,
  output logic              l2_write,
  output logic              l2_src,
  input  logic              l2_ready,
  output logic [CNT_W-1:0]  grants_i,
  output logic [CNT_W-1:0]  grants_d,
  output logic [CNT_W-1:0]  stall_cycles
);
  typedef enum logic {SLOT_EMPTY, SLOT_HELD} slot_state_t;

  localparam logic SRC_I = 1'b0;
  localparam logic SRC_D = 1'b1;

  slot_state_t      state_q, state_d;
  logic             last_grant;
  logic             grant_i, grant_d, slot_free;
  logic             i_not_empty, d_not_empty;
  logic [ADDR_W-1:0] i_head;
  logic [ADDR_W:0]   d_head;

  l2_req_fifo #(.W(ADDR_W), .DEPTH(DEPTH)) u_i_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (i_req_valid && i_req_ready),
    .push_data (i_req_addr),
    .pop       (grant_i),
    .head      (i_head),
    .not_full  (i_req_ready),
    .not_empty (i_not_empty)
  );

  l2_req_fifo #(.W(ADDR_W + 1), .DEPTH(DEPTH)) u_d_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (d_req_valid && d_req_ready),
    .push_data ({d_req_write, d_req_addr}),
    .pop       (grant_d),
    .head      (d_head),
    .not_full  (d_req_ready),
    .not_empty (d_not_empty)
  );

  assign l2_valid  = (state_q == SLOT_HELD);
  assign slot_free = !l2_valid || l2_ready;

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    state_d = state_q;
    if (slot_free) begin
      if (i_not_empty && d_not_empty) begin
        grant_d = (last_grant == SRC_I);
        grant_i = !grant_d;
      end else begin
        grant_i = i_not_empty;
        grant_d = d_not_empty;
      end
      state_d = (grant_i || grant_d) ? SLOT_HELD : SLOT_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= SLOT_EMPTY;
      l2_addr    <= '0;
      l2_write   <= 1'b0;
      l2_src     <= SRC_I;
      last_grant <= SRC_D;
    end else begin
      state_q <= state_d;
      if (grant_i) begin
        l2_addr    <= i_head;
        l2_write   <= 1'b0;
        l2_src     <= SRC_I;
        last_grant <= SRC_I;
      end else if (grant_d) begin
        l2_addr    <= d_head[ADDR_W-1:0];
        l2_write   <= d_head[ADDR_W];
        l2_src     <= SRC_D;
        last_grant <= SRC_D;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grants_i     <= '0;
      grants_d     <= '0;
      stall_cycles <= '0;
    end else begin
      if (grant_i)               grants_i     <= grants_i + CNT_W'(1);
      if (grant_d)               grants_d     <= grants_d + CNT_W'(1);
      if (l2_valid && !l2_ready) stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_l2_req_arbiter.sv
// Directed bench for l2_req_arbiter: reset, latency, round-robin, back-pressure, full FIFO, mid-run reset.
module tb_l2_req_arbiter;
  localparam int ADDR_W = 26;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_req_valid, i_req_ready;
  logic [ADDR_W-1:0] i_req_addr;
  logic              d_req_valid, d_req_write, d_req_ready;
  logic [ADDR_W-1:0] d_req_addr;
  logic              l2_valid, l2_write, l2_src, l2_ready;
  logic [ADDR_W-1:0] l2_addr;
  logic [CNT_W-1:0]  grants_i, grants_d, stall_cycles;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  l2_req_arbiter #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_req_valid  (i_req_valid),
    .i_req_addr   (i_req_addr),
    .i_req_ready  (i_req_ready),
    .d_req_valid  (d_req_valid),
    .d_req_addr   (d_req_addr),
    .d_req_write  (d_req_write),
    .d_req_ready  (d_req_ready),
    .l2_valid     (l2_valid),
    .l2_addr      (l2_addr),
    .l2_write     (l2_write),
    .l2_src       (l2_src),
    .l2_ready     (l2_ready),
    .grants_i     (grants_i),
    .grants_d     (grants_d),
    .stall_cycles (stall_cycles)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  int accepted;

  initial begin
    rst = 1'b1; l2_ready = 1'b0;
    i_req_valid = 1'b1; i_req_addr = 26'h0000123;
    d_req_valid = 1'b0; d_req_addr = '0; d_req_write = 1'b0;

    // Reset held two cycles with a pending instruction request.
    tick(); tick();
    rst = 1'b0; i_req_valid = 1'b0;
    check("rst_valid", l2_valid, 0);
    check("rst_addr", l2_addr, 0);
    check("rst_src", l2_src, 0);
    check("rst_write", l2_write, 0);
    check("rst_grants_i", grants_i, 0);
    check("rst_grants_d", grants_d, 0);
    check("rst_stall", stall_cycles, 0);
    check("rst_i_ready", i_req_ready, 1);
    check("rst_d_ready", d_req_ready, 1);
    tick(); tick();
    check("rst_nothing_queued", l2_valid, 0);

    // Single instruction request.
    l2_ready = 1'b1;
    i_req_valid = 1'b1; i_req_addr = 26'h0ABCDEF;
    tick();
    i_req_valid = 1'b0;
    check("single_not_same_edge", l2_valid, 0);
    tick();
    check("single_valid", l2_valid, 1);
    check("single_addr", l2_addr, 26'h0ABCDEF);
    check("single_src", l2_src, 0);
    check("single_grants_i", grants_i, 1);
    tick();
    check("single_drained", l2_valid, 0);

    // Round-robin: restore last_grant=data so instruction wins the first tie.
    do_reset();
    i_req_valid = 1'b1; i_req_addr = 26'h0002000;
    d_req_valid = 1'b1; d_req_addr = 26'h0001000; d_req_write = 1'b1;
    tick();
    i_req_addr = 26'h0002001;
    d_req_addr = 26'h0001001; d_req_write = 1'b0;
    tick();
    i_req_valid = 1'b0; d_req_valid = 1'b0;
    check("rr_i0_addr", l2_addr, 26'h0002000);
    check("rr_i0_src", l2_src, 0);
    check("rr_i0_write", l2_write, 0);
    tick();
    check("rr_d0_addr", l2_addr, 26'h0001000);
    check("rr_d0_src", l2_src, 1);
    check("rr_d0_write", l2_write, 1);
    tick();
    check("rr_i1_addr", l2_addr, 26'h0002001);
    check("rr_i1_src", l2_src, 0);
    tick();
    check("rr_d1_addr", l2_addr, 26'h0001001);
    check("rr_d1_src", l2_src, 1);
    check("rr_d1_write", l2_write, 0);
    check("rr_grants_i", grants_i, 2);
    check("rr_grants_d", grants_d, 2);
    tick();
    check("rr_drained", l2_valid, 0);

    // Back-pressure: slot held for 5 stalled edges, second request waits behind it.
    l2_ready = 1'b0;
    i_req_valid = 1'b1; i_req_addr = 26'h0003000;
    tick();
    i_req_addr = 26'h0003001;
    tick();
    i_req_valid = 1'b0;
    check("bp_held", l2_valid, 1);
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("bp_addr_stable%0d", k), l2_addr, 26'h0003000);
      check($sformatf("bp_src_stable%0d", k), l2_src, 0);
    end
    check("bp_stall", stall_cycles, 5);
    check("bp_no_pop", grants_i, 3);
    l2_ready = 1'b1;
    tick();
    check("bp_next_addr", l2_addr, 26'h0003001);
    check("bp_next_valid", l2_valid, 1);
    check("bp_stall_hold", stall_cycles, 5);
    tick();
    check("bp_drained", l2_valid, 0);

    // FIFO full: one in the slot plus DEPTH queued.
    l2_ready = 1'b0;
    accepted = 0;
    d_req_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      d_req_addr  = 26'h0004000 + ADDR_W'(accepted);
      d_req_write = accepted[0];
      if (d_req_ready) accepted++;
      tick();
    end
    d_req_valid = 1'b0;
    check("full_accepted", accepted, 5);
    check("full_ready", d_req_ready, 0);
    check("full_head_addr", l2_addr, 26'h0004000);
    l2_ready = 1'b1;
    for (int k = 1; k < 5; k++) begin
      tick();
      check($sformatf("full_drain_addr%0d", k), l2_addr, 26'h0004000 + k);
      check($sformatf("full_drain_write%0d", k), l2_write, k % 2);
    end
    check("full_grants_d", grants_d, 7);
    tick();
    check("full_drained", l2_valid, 0);

    // Reset while HELD with 3 queued entries.
    l2_ready = 1'b0;
    i_req_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      i_req_addr = 26'h0005000 + ADDR_W'(k);
      tick();
    end
    i_req_valid = 1'b0;
    check("mid_held", l2_valid, 1);
    l2_ready = 1'b1;
    do_reset();
    check("mid_valid", l2_valid, 0);
    check("mid_grants_i", grants_i, 0);
    check("mid_stall", stall_cycles, 0);
    check("mid_i_ready", i_req_ready, 1);
    tick(); tick();
    check("mid_queue_empty", l2_valid, 0);
    i_req_valid = 1'b1; i_req_addr = 26'h0006000;
    d_req_valid = 1'b1; d_req_addr = 26'h0006001; d_req_write = 1'b1;
    tick();
    i_req_valid = 1'b0; d_req_valid = 1'b0;
    tick();
    check("mid_first_src", l2_src, 0);
    check("mid_first_addr", l2_addr, 26'h0006000);
    tick();
    check("mid_second_src", l2_src, 1);
    check("mid_second_addr", l2_addr, 26'h0006001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
